ram_burst_reader: RTL and testbench

Burst read engine for the port-B side of the team's true dual-port RAM. It accepts a command of start address and word count, issues sequential single-cycle reads to the RAM port, absorbs the RAM's 1-cycle read latency, and presents the words as a valid/ready stream with a last-beat marker. It sits directly downstream of the RAM and feeds DMA or packet-transmit logic that cannot tolerate fixed-latency data.

---
 rtl/ram_burst_reader.sv | 165 ++++++++++++++++
 tb/tb_ram_burst_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// Burst read engine for a RAM read port: turns (addr, len) commands into
// sequential reads and re-times the 1-cycle-latency data onto a valid/ready stream.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [DATA_WIDTH-1:0] buf_data_d [2];
  logic [1:0]            buf_last_q, buf_last_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  rem_is_one;
  logic [2:0]            occ;
  logic [2:0]            limit;

  assign m_valid    = (count_q != 2'd0);
  assign m_data     = buf_data_q[rd_ptr_q];
  assign m_last     = m_valid & buf_last_q[rd_ptr_q];
  assign cmd_ready  = (state_q == IDLE);
  assign busy       = busy_q;
  assign done       = done_q;
  assign ram_we     = 1'b0;
  assign ram_addr   = addr_q;
  assign ram_en     = issue;

  assign push       = inflight_q;
  assign pop        = m_valid & m_ready;
  assign rem_is_one = (rem_q == LEN_WIDTH'(1));

  // A new read may only go out if the buffer can still take it when it lands:
  // words already buffered plus the one in flight, less the one leaving now.
  assign occ   = {2'b00, inflight_q} + {1'b0, count_q};
  assign limit = 3'd2 + {2'b00, pop};
  assign issue = (state_q == RUN) && (rem_q != '0) && (occ < limit);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    buf_data_d      = buf_data_q;
    buf_last_d      = buf_last_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    inflight_d      = issue;
    inflight_last_d = issue & rem_is_one;
    count_d         = count_q + {1'b0, push} - {1'b0, pop};

    if (push) begin
      buf_data_d[wr_ptr_q] = ram_dout;
      buf_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (issue) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      rem_d  = rem_q - LEN_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          if (cmd_len != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue && rem_is_one) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // No reads are issued here, so an empty next buffer means the tail is out.
        if (count_d == 2'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_data_q[0]   <= '0;
      buf_data_q[1]   <= '0;
      buf_last_q      <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      buf_data_q[0]   <= buf_data_d[0];
      buf_data_q[1]   <= buf_data_d[1];
      buf_last_q      <= buf_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader: commands push expected addresses, words,
// first-beat and done cycles; a negedge monitor pops and compares them.
module tb_ram_burst_reader;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last, busy, done;

  always #5 clk = ~clk;

  ram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  logic [DW-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
  always @(posedge clk) if (ram_en) ram_dout <= ram[ram_addr];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] q_addr [$];
  logic [DW-1:0] q_data [$];
  bit            q_last [$];
  int            q_done [$];
  int            q_first [$];
  int outstanding = 0;
  int beats = 0;
  int dones = 0;
  int last_done_cyc = -1;
  bit new_burst = 1'b1;
  bit rmode = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  initial forever begin
    @(posedge clk); #1;
    m_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      q_addr.delete(); q_data.delete(); q_last.delete(); q_done.delete(); q_first.delete();
      outstanding = 0;
      new_burst   = 1'b1;
      prev_stall  = 1'b0;
    end else begin
      if (ram_en) begin
        if (q_addr.size() == 0) fail_now("ram_en_unexpected");
        else check("ram_addr", 64'(ram_addr), 64'(q_addr.pop_front()));
        check("ram_we", 64'(ram_we), 64'd0);
        check("issue_with_full_buffer", 64'((outstanding - int'(m_valid && m_ready)) < 2), 64'd1);
      end
      if (prev_stall) begin
        check("stall_valid", 64'(m_valid), 64'd1);
        check("stall_data", 64'(m_data), 64'(prev_data));
        check("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && new_burst) begin
        if (q_first.size() == 0) fail_now("m_valid_unexpected");
        else check("first_beat_cycle", 64'(cyc), 64'(q_first.pop_front()));
        new_burst = 1'b0;
      end
      if (m_valid) check("busy_during_stream", 64'(busy), 64'd1);
      if (m_valid && m_ready) begin
        beats++;
        if (q_data.size() == 0) fail_now("extra_beat");
        else begin
          bit el;
          el = q_last.pop_front();
          check("m_data", 64'(m_data), 64'(q_data.pop_front()));
          check("m_last", 64'(m_last), 64'(el));
          if (el) begin
            q_done.push_back(cyc + 1);
            new_burst = 1'b1;
          end
        end
      end
      if (done) begin
        dones++;
        last_done_cyc = cyc;
        if (q_done.size() == 0) fail_now("done_unexpected");
        else check("done_cycle", 64'(cyc), 64'(q_done.pop_front()));
        check("busy_at_done", 64'(busy), 64'd0);
      end
      outstanding = outstanding + int'(ram_en) - int'(m_valid && m_ready);
      prev_stall  = m_valid && !m_ready;
      prev_data   = m_data;
      prev_last   = m_last;
    end
  end

  // Called just after a posedge; returns just after the posedge following acceptance.
  task automatic issue(input logic [AW-1:0] a, input int n, output int t);
    bit ok = 1'b0;
    t = -1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = LW'(n);
    for (int k = 0; k < 4000 && !ok; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        t  = cyc;
        for (int j = 0; j < n; j++) begin
          logic [AW-1:0] aj;
          aj = AW'(int'(a) + j);
          q_addr.push_back(aj);
          q_data.push_back(ram[aj]);
          q_last.push_back(j == n - 1);
        end
        if (n == 0) q_done.push_back(t + 1);
        else        q_first.push_back(t + 3);
      end
    end
    if (!ok) fail_now("cmd_accept_timeout");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
    cmd_len   = LW'($urandom_range(1, 5));
  endtask

  task automatic wait_dones(input int target, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      if (dones >= target) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) fail_now("done_timeout");
  endtask

  task automatic run_burst(input logic [AW-1:0] a, input int n, input bit mode);
    int t, d0;
    rmode = mode;
    d0 = dones;
    issue(a, n, t);
    check("busy_after_accept", 64'(busy), 64'(n != 0));
    wait_dones(d0 + 1, n * 8 + 60);
    if (!mode && n != 0) check("sustained_done_cycle", 64'(last_done_cyc), 64'(t + 3 + n));
  endtask

  initial begin
    int t0, t1, d0, b0;
    bit ok;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;

    run_burst(10'h010, 4, 1'b0);
    run_burst(10'h3FE, 4, 1'b0);

    rmode = 1'b0;
    d0 = dones;
    issue(10'h123, 0, t0);
    check("len0_busy", 64'(busy), 64'd0);
    issue(10'h100, 2, t1);
    check("len0_next_accept", 64'(t1), 64'(t0 + 1));
    wait_dones(d0 + 2, 100);

    run_burst(10'h040, 8, 1'b1);
    run_burst(10'h200, 1024, 1'b0);

    for (int i = 0; i < 16; i++)
      run_burst(AW'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));

    rmode = 1'b1;
    d0 = dones;
    b0 = beats;
    issue(10'h080, 8, t0);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (beats >= b0 + 3) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) fail_now("midburst_beats_timeout");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_m_last", 64'(m_last), 64'd0);
    check("midrst_m_data", 64'(m_data), 64'd0);
    check("midrst_ram_en", 64'(ram_en), 64'd0);
    check("midrst_ram_addr", 64'(ram_addr), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (6) begin @(posedge clk); #1; end
    check("midrst_no_done", 64'(dones), 64'(d0));
    run_burst(10'h020, 2, 1'b0);

    repeat (4) begin @(posedge clk); #1; end
    check("end_q_data_empty", 64'(q_data.size()), 64'd0);
    check("end_q_addr_empty", 64'(q_addr.size()), 64'd0);
    check("end_q_done_empty", 64'(q_done.size()), 64'd0);
    check("end_q_first_empty", 64'(q_first.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
